// File: rtl/layer_sched.sv
// Layer scheduler: queues per-layer descriptors and launches them one at a time
// on the global-buffer controller, counting layer and output-map completions.
module layer_sched #(
    parameter int AW    = 32,
    parameter int DEPTH = 8,
    parameter int MCW   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sys_ena,
    input  logic          desc_wr,
    input  logic [31:0]   desc_cmd,
    input  logic [AW-1:0] desc_daddr,
    input  logic [AW-1:0] desc_waddr,
    output logic          desc_full,
    output logic          desc_empty,
    input  logic          start,
    input  logic          abort,
    output logic [31:0]   comp_cmd,
    output logic [AW-1:0] data_init_addr,
    output logic [AW-1:0] weight_init_addr,
    input  logic          glb_done,
    input  logic          mapend,
    output logic          busy,
    output logic          all_done,
    output logic [7:0]    layer_cnt,
    output logic [MCW-1:0] map_cnt,
    output logic          err,
    output logic          ovf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          state_q, state_d;
    logic [30:0]     cmd_mem   [DEPTH];
    logic [AW-1:0]   daddr_mem [DEPTH];
    logic [AW-1:0]   waddr_mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [30:0]     cur_cmd_q, cur_cmd_d;
    logic [AW-1:0]   cur_daddr_q, cur_daddr_d, cur_waddr_q, cur_waddr_d;
    logic [31:0]     comp_cmd_q, comp_cmd_d;
    logic            busy_q, busy_d, all_done_q, all_done_d, err_q, err_d, ovf_q, ovf_d;
    logic [7:0]      layer_cnt_q, layer_cnt_d;
    logic [MCW-1:0]  map_cnt_q, map_cnt_d;
    logic            full, empty, push, pop;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign push  = desc_wr && !full && !abort;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        cur_cmd_d   = cur_cmd_q;
        cur_daddr_d = cur_daddr_q;
        cur_waddr_d = cur_waddr_q;
        comp_cmd_d  = comp_cmd_q;
        busy_d      = busy_q;
        all_done_d  = all_done_q;
        err_d       = err_q;
        ovf_d       = ovf_q;
        layer_cnt_d = layer_cnt_q;
        map_cnt_d   = map_cnt_q;
        pop         = 1'b0;

        if (abort) begin
            state_d    = IDLE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            cnt_d      = '0;
            comp_cmd_d = '0;
            busy_d     = 1'b0;
            all_done_d = 1'b0;
        end else begin
            if (sys_ena) begin
                all_done_d = 1'b0;
                unique case (state_q)
                    IDLE: begin
                        if (glb_done) err_d = 1'b1;
                        if (start && !empty) begin
                            pop         = 1'b1;
                            layer_cnt_d = '0;
                            err_d       = 1'b0;
                            ovf_d       = 1'b0;
                            state_d     = ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (glb_done) err_d = 1'b1;
                        state_d = WAIT;
                    end
                    WAIT: begin
                        if (mapend && (map_cnt_q != '1)) map_cnt_d = map_cnt_q + MCW'(1);
                        if (glb_done) begin
                            layer_cnt_d = layer_cnt_q + 8'd1;
                            if (!empty) begin
                                pop     = 1'b1;
                                state_d = ISSUE;
                            end else begin
                                state_d    = IDLE;
                                all_done_d = 1'b1;
                            end
                        end
                    end
                    default: state_d = IDLE;
                endcase

                if (pop) begin
                    cur_cmd_d   = cmd_mem[rd_ptr_q];
                    cur_daddr_d = daddr_mem[rd_ptr_q];
                    cur_waddr_d = waddr_mem[rd_ptr_q];
                    rd_ptr_d    = rd_ptr_q + PW'(1);
                end
                if (state_d == ISSUE) map_cnt_d = '0;

                // Outputs are registered, so they are derived from the next state.
                unique case (state_d)
                    ISSUE:   comp_cmd_d = {1'b1, cur_cmd_d};
                    WAIT:    comp_cmd_d = {1'b0, cur_cmd_d};
                    default: comp_cmd_d = '0;
                endcase
                busy_d = (state_d != IDLE);
            end

            if (desc_wr && full) ovf_d = 1'b1;
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            cmd_mem[wr_ptr_q]   <= desc_cmd[30:0];
            daddr_mem[wr_ptr_q] <= desc_daddr;
            waddr_mem[wr_ptr_q] <= desc_waddr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            cur_cmd_q   <= '0;
            cur_daddr_q <= '0;
            cur_waddr_q <= '0;
            comp_cmd_q  <= '0;
            busy_q      <= 1'b0;
            all_done_q  <= 1'b0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            layer_cnt_q <= '0;
            map_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            cur_cmd_q   <= cur_cmd_d;
            cur_daddr_q <= cur_daddr_d;
            cur_waddr_q <= cur_waddr_d;
            comp_cmd_q  <= comp_cmd_d;
            busy_q      <= busy_d;
            all_done_q  <= all_done_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            layer_cnt_q <= layer_cnt_d;
            map_cnt_q   <= map_cnt_d;
        end
    end

    assign desc_full        = full;
    assign desc_empty       = empty;
    assign comp_cmd         = comp_cmd_q;
    assign data_init_addr   = cur_daddr_q;
    assign weight_init_addr = cur_waddr_q;
    assign busy             = busy_q;
    assign all_done         = all_done_q;
    assign layer_cnt        = layer_cnt_q;
    assign map_cnt          = map_cnt_q;
    assign err              = err_q;
    assign ovf              = ovf_q;
endmodule
